// File: rtl/saph_plr_ctl_pkg.sv
// Shared sizing helpers for the pipeline-register issue/credit controller and its FIFO.
package saph_plr_ctl_pkg;

    // Counter width able to hold 0..n inclusive.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n == 32'd0) ? 32'd1 : $clog2(n + 32'd1);
    endfunction

    // Pointer width able to address n entries; never narrower than one bit.
    function automatic int unsigned ptr_bits(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/saph_fifo_fwft.sv
// First-word fall-through FIFO with explicit pointer wrap, so any depth >= 1 works.
module saph_fifo_fwft
    import saph_plr_ctl_pkg::*;
#(
    parameter int unsigned width = 32,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned ptr_w = ptr_bits(depth);
    localparam int unsigned cnt_w = cnt_bits(depth);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth - 32'd1);
    localparam logic [ptr_w-1:0] ptr_one  = ptr_w'(32'd1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);
    localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(32'd1);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A pop frees its slot first, so push-while-full is accepted when paired with a pop.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign full     = (count == full_cnt);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + ptr_one;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + ptr_one;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + cnt_one;
                2'b01:   count <= count - cnt_one;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/saph_fifo_fwft_chk.sv
// Protocol checker for saph_fifo_fwft: a push may only land on a full FIFO when a pop frees a slot.
module saph_fifo_fwft_chk (
    input logic clk,
    input logic rst_n,
    input logic clear,
    input logic push,
    input logic pop,
    input logic full
);

    // Overflow is impossible when credits are respected; a hit here means a credit leak.
    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n || clear)
        !(push && full && !pop));

endmodule

// File: rtl/saph_plr_ctl.sv
// Issue/credit controller wrapping a fixed-latency, non-stallable datapath with a valid/ready interface.
module saph_plr_ctl
    import saph_plr_ctl_pkg::*;
#(
    parameter int unsigned width   = 32,
    parameter int unsigned latency = 2,
    parameter int unsigned depth   = latency + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             pipe_en,
    output logic [width-1:0] pipe_d,
    input  logic [width-1:0] pipe_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic             busy
);

    localparam int unsigned occ_w = cnt_bits(depth);
    localparam logic [occ_w-1:0] occ_max = occ_w'(depth);
    localparam logic [occ_w-1:0] occ_one = occ_w'(32'd1);

    logic [occ_w-1:0] occ;
    logic             arrival;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    // occ counts in-flight plus buffered items, so an issued item always has a FIFO slot.
    assign in_ready  = (occ < occ_max) & ~flush & rst_n;
    assign pipe_en   = in_valid & in_ready;
    assign pipe_d    = in_data;
    assign out_valid = ~fifo_empty;
    assign fifo_pop  = out_valid & out_ready;
    assign fifo_push = arrival & ~flush;
    assign busy      = (occ != '0);

    generate
        if (latency == 0) begin : g_no_vld
            assign arrival = pipe_en;
        end else begin : g_vld
            logic [latency-1:0] vld;

            // Valid bits travel alongside the datapath registers.
            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    vld <= '0;
                end else begin
                    vld[0] <= pipe_en;
                    for (int i = 1; i < int'(latency); i++) begin
                        vld[i] <= vld[i-1];
                    end
                end
            end

            assign arrival = vld[latency-1];
        end
    endgenerate

    // Credit counter: issue takes a credit, output handshake returns one.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            occ <= '0;
        end else begin
            case ({pipe_en, fifo_pop})
                2'b10:   occ <= occ + occ_one;
                2'b01:   occ <= occ - occ_one;
                default: occ <= occ;
            endcase
        end
    end

    saph_fifo_fwft #(
        .width (width),
        .depth (depth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (pipe_q),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    saph_fifo_fwft_chk u_fifo_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_saph_plr_ctl.sv
// Directed bench: latency-2/depth-4 instance driven from a vector table, plus a latency-0/depth-2 instance.
module tb_saph_plr_ctl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_flush, a_iv, a_ir, a_pe, a_or, a_ov, a_busy;
    logic [7:0] a_id, a_pd, a_pq, a_od, a_s1, a_s2;
    logic       b_flush, b_iv, b_ir, b_pe, b_or, b_ov, b_busy;
    logic [7:0] b_id, b_pd, b_od;

    int checks   = 0;
    int failures = 0;

    saph_plr_ctl #(.width(8), .latency(2), .depth(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .pipe_en(a_pe), .pipe_d(a_pd), .pipe_q(a_pq), .out_valid(a_ov),
        .out_ready(a_or), .out_data(a_od), .busy(a_busy)
    );

    saph_plr_ctl #(.width(8), .latency(0), .depth(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .pipe_en(b_pe), .pipe_d(b_pd), .pipe_q(b_pd), .out_valid(b_ov),
        .out_ready(b_or), .out_data(b_od), .busy(b_busy)
    );

    // Two-stage datapath stub, free-running like a real non-stallable pipeline.
    always @(posedge clk) begin
        a_s1 <= a_pd;
        a_s2 <= a_s1;
    end
    assign a_pq = a_s2;

    typedef struct {
        logic       r, f, iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir, e_pe, e_ov;
        logic [7:0] e_od;
        logic       e_bz;
        logic       c_od;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, f, iv, input logic [7:0] id, input logic ordy,
                                input logic e_ir, e_pe, e_ov, input logic [7:0] e_od,
                                input logic e_bz, c_od);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_pe = e_pe; v.e_ov = e_ov; v.e_od = e_od; v.e_bz = e_bz; v.c_od = c_od;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] e;
        logic [7:0] bdat [8];

        rst_n = 1'b0;
        a_flush = 1'b0; a_iv = 1'b0; a_id = 8'h00; a_or = 1'b0;
        b_flush = 1'b0; b_iv = 1'b0; b_id = 8'h00; b_or = 1'b0;
        repeat (2) @(posedge clk);

        // reset held 3 cycles with in_valid asserted
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0,1'b0,1'b1,8'h11,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b0));
        // single item
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'hA5,1'b1, 1'b1,1'b1,1'b0,8'h00,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h00,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h00,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b1,8'hA5,1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0));
        // backpressure: only 0x01..0x04 accepted
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h01,1'b0, 1'b1,1'b1,1'b0,8'h00,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h02,1'b0, 1'b1,1'b1,1'b0,8'h00,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h03,1'b0, 1'b1,1'b1,1'b0,8'h00,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h04,1'b0, 1'b1,1'b1,1'b1,8'h01,1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h05,1'b0, 1'b0,1'b0,1'b1,8'h01,1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h05,1'b0, 1'b0,1'b0,1'b1,8'h01,1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b1,8'h01,1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b1,8'h02,1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b1,8'h03,1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b1,8'h04,1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0));
        // flush with 2 buffered and 2 in flight
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h21,1'b0, 1'b1,1'b1,1'b0,8'h00,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h22,1'b0, 1'b1,1'b1,1'b0,8'h00,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h23,1'b0, 1'b1,1'b1,1'b0,8'h00,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,8'h24,1'b0, 1'b1,1'b1,1'b1,8'h21,1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b1,1'b1,8'h25,1'b1, 1'b0,1'b0,1'b1,8'h21,1'b1,1'b1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].r; a_flush = tbl[i].f; a_iv = tbl[i].iv; a_id = tbl[i].id; a_or = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(a_ir), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d_pipe_en", i), 32'(a_pe), 32'(tbl[i].e_pe));
            chk($sformatf("v%0d_out_valid", i), 32'(a_ov), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'(tbl[i].e_bz));
            if (tbl[i].c_od) chk($sformatf("v%0d_out_data", i), 32'(a_od), 32'(tbl[i].e_od));
        end

        // throughput: 16 back-to-back items out on 16 consecutive cycles from c3
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            a_iv = (i < 16); a_id = 8'h40 + 8'(i); a_or = 1'b1;
            #1;
            chk($sformatf("tp%0d_in_ready", i), 32'(a_ir), 32'd1);
            chk($sformatf("tp%0d_pipe_en", i), 32'(a_pe), 32'((i < 16) ? 1 : 0));
            chk($sformatf("tp%0d_out_valid", i), 32'(a_ov), 32'((i >= 3 && i < 19) ? 1 : 0));
            if (i >= 3 && i < 19) begin
                e = 8'h40 + 8'(i - 3);
                chk($sformatf("tp%0d_out_data", i), 32'(a_od), 32'(e));
            end
        end
        a_iv = 1'b0;

        // latency 0, depth 2: result one cycle after issue, full rate
        for (int k = 0; k < 8; k++) bdat[k] = 8'h3C ^ 8'(k * 17);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b_iv = (i < 8); b_id = (i < 8) ? bdat[i] : 8'h00; b_or = 1'b1;
            #1;
            chk($sformatf("l0_%0d_in_ready", i), 32'(b_ir), 32'd1);
            chk($sformatf("l0_%0d_pipe_en", i), 32'(b_pe), 32'((i < 8) ? 1 : 0));
            chk($sformatf("l0_%0d_out_valid", i), 32'(b_ov), 32'((i >= 1 && i <= 8) ? 1 : 0));
            if (i >= 1 && i <= 8) chk($sformatf("l0_%0d_out_data", i), 32'(b_od), 32'(bdat[i-1]));
            if (i == 9) chk("l0_busy_idle", 32'(b_busy), 32'd0);
        end
        b_iv = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
